mult_div_unit: RTL

Iterative 32-bit multiply/divide unit for the MIPS datapath. Executes MULT, MULTU, DIV and DIVU over multiple cycles and holds results in architectural HI/LO registers. HI and LO feed the 32-bit 8:1 result-select mux directly upstream of the register-file write port, as the mfhi/mflo inputs. Also supports mthi/mtlo writes. The start/busy/done handshake stalls the control unit.

---
 rtl/mult_div_unit.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// Iterative WIDTH-bit multiply/divide unit with architectural HI/LO registers.
// Shift-add multiply and restoring divide run over WIDTH cycles; the sign is fixed after the magnitude loop.
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             wr_hi,
   input  logic             wr_lo,
   input  logic [WIDTH-1:0] wr_data,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q;
   logic               is_div_q, neg_res_q, neg_rem_q, dbz_q;
   logic [WIDTH-1:0]   opnd_q;
   logic [2*WIDTH-1:0] acc_q, acc_nx;
   logic [WIDTH-1:0]   hi_q, lo_q;

   logic             is_div, a_neg, b_neg, b_zero, accept, last_iter;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic [WIDTH-1:0] res_hi, res_lo;

   assign is_div    = op[1];
   assign a_neg     = ~op[0] & a[WIDTH-1];
   assign b_neg     = ~op[0] & b[WIDTH-1];
   assign a_mag     = a_neg ? -a : a;
   assign b_mag     = b_neg ? -b : b;
   assign b_zero    = (b == '0);
   assign accept    = start && (state_q != RUN);
   assign last_iter = (cnt_q == CW'(WIDTH - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, FIN: begin
            if (start) begin
               state_d = (is_div && b_zero) ? FIN : RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            if (last_iter) begin
               state_d = FIN;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy        = (state_q == RUN);
      done        = (state_q == FIN);
      div_by_zero = (state_q == FIN) && dbz_q;
   end

   // acc holds {partial product high, multiplier} or {remainder, dividend/quotient}.
   logic [WIDTH:0] mul_sum, rem_sh, diff;
   always_comb begin
      mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
      rem_sh  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      diff    = rem_sh - {1'b0, opnd_q};
      if (!is_div_q) begin
         acc_nx = {mul_sum, acc_q[WIDTH-1:1]};
      end else if (!diff[WIDTH]) begin
         acc_nx = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end else begin
         acc_nx = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end
   end

   logic [2*WIDTH-1:0] prod_fix;
   always_comb begin
      prod_fix = neg_res_q ? -acc_nx : acc_nx;
      if (is_div_q) begin
         res_lo = neg_res_q ? -acc_nx[WIDTH-1:0] : acc_nx[WIDTH-1:0];
         res_hi = neg_rem_q ? -acc_nx[2*WIDTH-1:WIDTH] : acc_nx[2*WIDTH-1:WIDTH];
      end else begin
         res_lo = prod_fix[WIDTH-1:0];
         res_hi = prod_fix[2*WIDTH-1:WIDTH];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         is_div_q  <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         dbz_q     <= 1'b0;
         opnd_q    <= '0;
         acc_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else if (accept) begin
         // A start in IDLE/FIN takes priority over any mthi/mtlo on the same edge.
         cnt_q     <= '0;
         is_div_q  <= is_div;
         neg_res_q <= a_neg ^ b_neg;
         neg_rem_q <= a_neg;
         dbz_q     <= is_div && b_zero;
         opnd_q    <= is_div ? b_mag : a_mag;
         acc_q     <= {{WIDTH{1'b0}}, (is_div ? a_mag : b_mag)};
         if (is_div && b_zero) begin
            hi_q <= a;
            lo_q <= '1;
         end
      end else if (state_q == RUN) begin
         acc_q <= acc_nx;
         cnt_q <= cnt_q + 1'b1;
         if (last_iter) begin
            hi_q <= res_hi;
            lo_q <= res_lo;
         end
      end else begin
         if (wr_hi) hi_q <= wr_data;
         if (wr_lo) lo_q <= wr_data;
      end
   end

   assign hi = hi_q;
   assign lo = lo_q;

endmodule
